// File: rtl/mpb_arb_pkg.sv
// Shared types and constants for the two-requester MPB arbiter.
package mpb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_t;

  localparam int unsigned CNT_W = 16;

  // Read data returned on a forced completion; sliced down to DATA_W by the user.
  localparam int unsigned ABORT_RDATA_MAX_W = 256;
  localparam logic [ABORT_RDATA_MAX_W-1:0] ABORT_RDATA = '1;

endpackage

// File: rtl/mpb_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module mpb_arb_rr
  import mpb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_gnt,
  output logic [1:0] win
);

  always_comb begin
    win = '0;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = (last_gnt == REQ1) ? 2'b01 : 2'b10;
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/mpb_arb.sv
// Arbiter sharing one MPB target between two requesters.
// Optional BUSY wait limit with forced completion: define MPB_ARB_TIMEOUT_EN.
module mpb_arb
  import mpb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_vld,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_rdy,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_vld,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rdy,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_vld,
  output logic              s_wr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_rdy,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        gnt
`ifdef MPB_ARB_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] win;
  req_idx_t   last_gnt_q, last_gnt_d;

  mpb_arb_rr u_rr (
    .req      ({m1_vld, m0_vld}),
    .last_gnt (last_gnt_q),
    .win      (win)
  );

`ifdef MPB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_expired;

  // Held at zero outside BUSY so every transfer starts counting from 0.
  always_ff @(posedge clk) begin
    if (!reset_n || state_q != BUSY) begin
      cnt_q <= '0;
    end else if (!s_rdy) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_gnt_q <= REQ1;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (win != '0) begin
          state_d    = BUSY;
          gnt_d      = win;
          last_gnt_d = win[1] ? REQ1 : REQ0;
        end
      end
      BUSY: begin
        if (s_rdy) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
`ifdef MPB_ARB_TIMEOUT_EN
        else if (cnt_expired) begin
          state_d = ABORT;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    s_vld    = 1'b0;
    s_wr     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    m0_rdy   = 1'b0;
    m0_rdata = '0;
    m1_rdy   = 1'b0;
    m1_rdata = '0;
`ifdef MPB_ARB_TIMEOUT_EN
    timeout  = 1'b0;
`endif
    if (state_q == BUSY) begin
      if (gnt_q[1]) begin
        s_vld    = m1_vld;
        s_wr     = m1_wr;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        m1_rdy   = s_rdy;
        m1_rdata = s_rdata;
      end else if (gnt_q[0]) begin
        s_vld    = m0_vld;
        s_wr     = m0_wr;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        m0_rdy   = s_rdy;
        m0_rdata = s_rdata;
      end
    end
`ifdef MPB_ARB_TIMEOUT_EN
    if (state_q == ABORT) begin
      timeout = 1'b1;
      if (gnt_q[1]) begin
        m1_rdy   = 1'b1;
        m1_rdata = ABORT_RDATA[DATA_W-1:0];
      end else if (gnt_q[0]) begin
        m0_rdy   = 1'b1;
        m0_rdata = ABORT_RDATA[DATA_W-1:0];
      end
    end
`endif
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_mpb_arb.sv
// Directed self-checking bench for mpb_arb; the timeout scenario runs when MPB_ARB_TIMEOUT_EN is defined.
module tb_mpb_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_vld, m0_wr, m1_vld, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_rdy, m1_rdy;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_vld, s_wr, s_rdy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  gnt;
`ifdef MPB_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mpb_arb #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .m0_vld   (m0_vld),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_rdy   (m0_rdy),
    .m0_rdata (m0_rdata),
    .m1_vld   (m1_vld),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_rdy   (m1_rdy),
    .m1_rdata (m1_rdata),
    .s_vld    (s_vld),
    .s_wr     (s_wr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdy    (s_rdy),
    .s_rdata  (s_rdata),
    .gnt      (gnt)
`ifdef MPB_ARB_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_vld = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_vld = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
    s_rdy  = 1'b0; s_rdata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    m0_vld = 1'b1; m1_vld = 1'b1; s_rdy = 1'b1; s_rdata = 32'hFFFF0000;
    tick(); tick(); #1;
    checks++;
    if ({gnt, s_vld, s_wr, m0_rdy, m1_rdy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", {gnt, s_vld, s_wr, m0_rdy, m1_rdy}, 6'b0);
    end
    checks++;
    if ({s_addr, s_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {s_addr, s_wdata, m0_rdata, m1_rdata});
    end
    reset_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_single_write();
    m0_vld = 1'b1; m0_wr = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hA5A5A5A5;
    #1;
    checks++;
    if ({gnt, s_vld} !== 3'b000) begin
      failures++;
      $display("FAIL wr_c0_idle got=%b exp=000", {gnt, s_vld});
    end
    tick(); #1;
    checks++;
    if ({gnt, s_vld, s_wr, m0_rdy, m1_rdy} !== 6'b01_1_1_0_0) begin
      failures++;
      $display("FAIL wr_c1_ctrl got=%b exp=011100", {gnt, s_vld, s_wr, m0_rdy, m1_rdy});
    end
    checks++;
    if ({s_addr, s_wdata} !== {32'h10, 32'hA5A5A5A5}) begin
      failures++;
      $display("FAIL wr_c1_fields got=%h exp=%h", {s_addr, s_wdata}, {32'h10, 32'hA5A5A5A5});
    end
    tick(); #1;
    checks++;
    if ({gnt, s_vld, m0_rdy, m1_rdy} !== 5'b01_1_0_0) begin
      failures++;
      $display("FAIL wr_c2_wait got=%b exp=01100", {gnt, s_vld, m0_rdy, m1_rdy});
    end
    tick();
    s_rdy = 1'b1;
    #1;
    checks++;
    if ({gnt, s_vld, m0_rdy, m1_rdy} !== 5'b01_1_1_0) begin
      failures++;
      $display("FAIL wr_c3_done got=%b exp=01110", {gnt, s_vld, m0_rdy, m1_rdy});
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({gnt, s_vld, m0_rdy, m1_rdy, s_addr} !== 37'h0) begin
      failures++;
      $display("FAIL wr_c4_idle got=%h exp=0", {gnt, s_vld, m0_rdy, m1_rdy, s_addr});
    end
    tick();
  endtask

  task automatic test_tie();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    reset_n = 1'b1;
    m0_vld = 1'b1; m0_addr = 32'h100;
    m1_vld = 1'b1; m1_addr = 32'h200;
    s_rdy = 1'b1; s_rdata = 32'h55;
    #1;
    checks++;
    if (gnt !== 2'b00) begin
      failures++;
      $display("FAIL tie_c0_gnt got=%b exp=00", gnt);
    end
    tick(); #1;
    checks++;
    if ({gnt, m0_rdy, m1_rdy, s_addr, m0_rdata, m1_rdata} !== {2'b01, 1'b1, 1'b0, 32'h100, 32'h55, 32'h0}) begin
      failures++;
      $display("FAIL tie_first_m0 got=%h exp=%h", {gnt, m0_rdy, m1_rdy, s_addr, m0_rdata, m1_rdata},
               {2'b01, 1'b1, 1'b0, 32'h100, 32'h55, 32'h0});
    end
    tick();
    m0_vld = 1'b0; m0_addr = '0;
    #1;
    checks++;
    if ({gnt, m0_rdy, m1_rdy} !== 4'b00_0_0) begin
      failures++;
      $display("FAIL tie_gap got=%b exp=0000", {gnt, m0_rdy, m1_rdy});
    end
    tick(); #1;
    checks++;
    if ({gnt, m0_rdy, m1_rdy, s_addr, m0_rdata, m1_rdata} !== {2'b10, 1'b0, 1'b1, 32'h200, 32'h0, 32'h55}) begin
      failures++;
      $display("FAIL tie_second_m1 got=%h exp=%h", {gnt, m0_rdy, m1_rdy, s_addr, m0_rdata, m1_rdata},
               {2'b10, 1'b0, 1'b1, 32'h200, 32'h0, 32'h55});
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (gnt !== 2'b00) begin
      failures++;
      $display("FAIL tie_end_gnt got=%b exp=00", gnt);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned i0 = 0;
    int unsigned i1 = 0;
    logic        owner0;
    logic [31:0] exp_addr;
    for (int unsigned c = 0; c < 16; c++) begin
      m0_vld = (i0 < 4); m0_wr = 1'b0; m0_addr = 32'h1000 + i0 * 4;
      m1_vld = (i1 < 4); m1_wr = 1'b0; m1_addr = 32'h2000 + i1 * 4;
      s_rdy = 1'b1;
      #1;
      s_rdata = s_addr;
      #1;
      if (c % 2 == 0) begin
        checks++;
        if ({gnt, s_vld, m0_rdy, m1_rdy} !== 5'b0) begin
          failures++;
          $display("FAIL b2b_idle c=%0d got=%b exp=00000", c, {gnt, s_vld, m0_rdy, m1_rdy});
        end
      end else begin
        owner0   = ((c / 2) % 2 == 0);
        exp_addr = owner0 ? 32'h1000 + i0 * 4 : 32'h2000 + i1 * 4;
        checks++;
        if ({gnt, s_vld, m0_rdy, m1_rdy} !== (owner0 ? 5'b01_1_1_0 : 5'b10_1_0_1)) begin
          failures++;
          $display("FAIL b2b_ctrl c=%0d got=%b exp=%b", c, {gnt, s_vld, m0_rdy, m1_rdy},
                   owner0 ? 5'b01_1_1_0 : 5'b10_1_0_1);
        end
        checks++;
        if ({s_addr, m0_rdata, m1_rdata} !== (owner0 ? {exp_addr, exp_addr, 32'h0} : {exp_addr, 32'h0, exp_addr})) begin
          failures++;
          $display("FAIL b2b_data c=%0d got=%h exp_addr=%h owner0=%b", c, {s_addr, m0_rdata, m1_rdata}, exp_addr, owner0);
        end
        if (owner0) i0++;
        else        i1++;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_idle_srdy();
    idle_inputs();
    s_rdy = 1'b1; s_rdata = 32'hCAFE0000;
    for (int unsigned c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({gnt, s_vld, m0_rdy, m1_rdy, m0_rdata, m1_rdata} !== 69'h0) begin
        failures++;
        $display("FAIL idle_srdy c=%0d got=%h exp=0", c, {gnt, s_vld, m0_rdy, m1_rdy, m0_rdata, m1_rdata});
      end
      tick();
    end
    m1_vld = 1'b1; m1_addr = 32'h300;
    tick(); #1;
    checks++;
    if ({gnt, m1_rdy, m0_rdy, s_addr} !== {2'b10, 1'b1, 1'b0, 32'h300}) begin
      failures++;
      $display("FAIL idle_then_grant got=%h exp=%h", {gnt, m1_rdy, m0_rdy, s_addr}, {2'b10, 1'b1, 1'b0, 32'h300});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    m0_vld = 1'b1; m0_addr = 32'h400;
    s_rdy = 1'b0;
    tick(); #1;
    checks++;
    if ({gnt, s_vld} !== 3'b01_1) begin
      failures++;
      $display("FAIL rst_mid_busy got=%b exp=011", {gnt, s_vld});
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m1_vld = 1'b1; m1_addr = 32'h500;
    #1;
    checks++;
    if ({gnt, s_vld, s_wr, m0_rdy, m1_rdy, s_addr, s_wdata, m0_rdata, m1_rdata} !== 134'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h exp=0", {gnt, s_vld, s_wr, m0_rdy, m1_rdy, s_addr, s_wdata, m0_rdata, m1_rdata});
    end
    tick(); #1;
    checks++;
    if ({gnt, s_addr} !== {2'b01, 32'h400}) begin
      failures++;
      $display("FAIL rst_tie_m0 got=%h exp=%h", {gnt, s_addr}, {2'b01, 32'h400});
    end
    s_rdy = 1'b1;
    #1;
    checks++;
    if ({m0_rdy, m1_rdy} !== 2'b10) begin
      failures++;
      $display("FAIL rst_m0_done got=%b exp=10", {m0_rdy, m1_rdy});
    end
    tick();
    m0_vld = 1'b0;
    tick(); #1;
    checks++;
    if ({gnt, m1_rdy, s_addr} !== {2'b10, 1'b1, 32'h500}) begin
      failures++;
      $display("FAIL rst_m1_after got=%h exp=%h", {gnt, m1_rdy, s_addr}, {2'b10, 1'b1, 32'h500});
    end
    tick();
    idle_inputs();
    tick();
  endtask

`ifdef MPB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    idle_inputs();
    m1_vld = 1'b1; m1_addr = 32'h600;
    s_rdata = 32'h12345678;
    tick();
    for (int unsigned c = 0; c < 8; c++) begin
      #1;
      checks++;
      if ({gnt, s_vld, m1_rdy, timeout} !== 5'b10_1_0_0) begin
        failures++;
        $display("FAIL to_wait c=%0d got=%b exp=10100", c, {gnt, s_vld, m1_rdy, timeout});
      end
      tick();
    end
    #1;
    checks++;
    if ({gnt, s_vld, m1_rdy, timeout, m0_rdy, m1_rdata} !== {2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL to_abort got=%h exp=%h", {gnt, s_vld, m1_rdy, timeout, m0_rdy, m1_rdata},
               {2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF});
    end
    tick();
    m1_vld = 1'b0;
    #1;
    checks++;
    if ({gnt, m1_rdy, timeout} !== 4'b0) begin
      failures++;
      $display("FAIL to_idle got=%b exp=0000", {gnt, m1_rdy, timeout});
    end
    tick();
    idle_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    tick();
    test_reset();
    test_single_write();
    test_tie();
    test_back_to_back();
    test_idle_srdy();
    test_reset_mid_busy();
`ifdef MPB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
